// File: rtl/enemy_pkg.sv
// Shared definitions for the enemy missile controller: slot count,
// coordinate width, the inactive-slot coordinate value and launch FSM states.
package enemy_pkg;

    localparam int N_EN_MISSILES = 5;
    localparam int COORD_W       = 11;
    localparam int SEL_W         = 3;

    typedef logic [COORD_W-1:0] coord_t;

    localparam coord_t INACTIVE_XY = 11'd0;

    typedef enum logic [1:0] {
        IDLE,
        QUERY,
        LAUNCH
    } launch_state_t;

    // Round-robin successor of a shooter index, wrapping after the last enemy
    function automatic logic [SEL_W-1:0] next_shooter(input logic [SEL_W-1:0] sel);
        return (sel == SEL_W'(N_EN_MISSILES - 1)) ? '0 : sel + 1'b1;
    endfunction

endpackage

// File: rtl/enemy_missile_ctl_if.sv
// Bundle between the missile controller, the enemy formation (shooter
// lookups) and the ship / missile drawing consumers.
interface enemy_missile_ctl_if;
    import enemy_pkg::*;

    logic [SEL_W-1:0]         shooter_sel;
    coord_t                   shooter_x;
    coord_t                   shooter_y;
    logic                     shooter_valid;

    coord_t                   en_x_missile1;
    coord_t                   en_x_missile2;
    coord_t                   en_x_missile3;
    coord_t                   en_x_missile4;
    coord_t                   en_x_missile5;
    coord_t                   en_y_missile1;
    coord_t                   en_y_missile2;
    coord_t                   en_y_missile3;
    coord_t                   en_y_missile4;
    coord_t                   en_y_missile5;
    logic [N_EN_MISSILES-1:0] missile_on;

    modport master (
        output shooter_sel,
        input  shooter_x, shooter_y, shooter_valid,
        output en_x_missile1, en_x_missile2, en_x_missile3, en_x_missile4, en_x_missile5,
        output en_y_missile1, en_y_missile2, en_y_missile3, en_y_missile4, en_y_missile5,
        output missile_on
    );

    modport slave (
        input  shooter_sel,
        output shooter_x, shooter_y, shooter_valid,
        input  en_x_missile1, en_x_missile2, en_x_missile3, en_x_missile4, en_x_missile5,
        input  en_y_missile1, en_y_missile2, en_y_missile3, en_y_missile4, en_y_missile5,
        input  missile_on
    );

endinterface

// File: rtl/enemy_missile_slot.sv
// One enemy missile: holds its position and active flag, loads on launch,
// falls by STEP per move tick and retires once it would pass Y_BOTTOM.
module enemy_missile_slot
    import enemy_pkg::*;
#(
    parameter int STEP     = 4,
    parameter int Y_BOTTOM = 767
) (
    input  logic   pclk,
    input  logic   rst,
    input  logic   clear,
    input  logic   load,
    input  coord_t load_x,
    input  coord_t load_y,
    input  logic   move_tick,
    output coord_t x,
    output coord_t y,
    output logic   on
);

    localparam logic [COORD_W:0] STEP_EXT   = (COORD_W + 1)'(STEP);
    localparam logic [COORD_W:0] BOTTOM_EXT = (COORD_W + 1)'(Y_BOTTOM);

    logic [COORD_W:0] y_sum;

    // Candidate position after one move, kept one bit wider to see the overflow past the bottom
    always_comb begin
        y_sum = {1'b0, y} + STEP_EXT;
    end

    // Slot state: clear beats launch, launch beats movement so a fresh missile starts unmoved
    always_ff @(posedge pclk) begin
        if (rst || clear) begin
            x  <= INACTIVE_XY;
            y  <= INACTIVE_XY;
            on <= 1'b0;
        end else if (load) begin
            x  <= load_x;
            y  <= load_y;
            on <= 1'b1;
        end else if (move_tick && on) begin
            if (y_sum > BOTTOM_EXT) begin
                x  <= INACTIVE_XY;
                y  <= INACTIVE_XY;
                on <= 1'b0;
            end else begin
                y <= y_sum[COORD_W-1:0];
            end
        end
    end

endmodule

// File: rtl/enemy_missile_ctl.sv
// Enemy missile controller: paces movement and launch attempts, queries the
// formation for a round-robin shooter and drops its missile into the lowest
// free slot. ship_down wipes and freezes everything until released.
module enemy_missile_ctl
    import enemy_pkg::*;
#(
    parameter int MOVE_DIV    = 20000,
    parameter int STEP        = 4,
    parameter int FIRE_PERIOD = 2000000,
    parameter int X_OFFSET    = 16,
    parameter int Y_OFFSET    = 32,
    parameter int Y_BOTTOM    = 767
) (
    input  logic                pclk,
    input  logic                rst,
    input  logic                ship_down,
    enemy_missile_ctl_if.master bus
);

    localparam int MOVE_W = 21;
    localparam int FIRE_W = 25;

    localparam logic [MOVE_W-1:0] MOVE_LAST = MOVE_W'(MOVE_DIV - 1);
    localparam logic [FIRE_W-1:0] FIRE_LAST = FIRE_W'(FIRE_PERIOD - 1);

    logic [MOVE_W-1:0]        move_cnt;
    logic [FIRE_W-1:0]        fire_cnt;
    logic                     move_tick;
    logic                     fire_req;

    launch_state_t            state_q;
    launch_state_t            state_d;
    logic [SEL_W-1:0]         shooter_sel_q;

    logic [N_EN_MISSILES-1:0] on_vec;
    logic [N_EN_MISSILES-1:0] first_free;
    logic [N_EN_MISSILES-1:0] load_vec;
    logic                     launch_en;
    coord_t                   launch_x;
    coord_t                   launch_y;
    coord_t                   slot_x [N_EN_MISSILES];
    coord_t                   slot_y [N_EN_MISSILES];

    assign move_tick = (move_cnt == MOVE_LAST);
    assign fire_req  = (fire_cnt == FIRE_LAST);

    // Free-running pacing counters, frozen at zero while the player is down
    always_ff @(posedge pclk) begin
        if (rst || ship_down) begin
            move_cnt <= '0;
            fire_cnt <= '0;
        end else begin
            move_cnt <= move_tick ? '0 : move_cnt + 1'b1;
            fire_cnt <= fire_req  ? '0 : fire_cnt + 1'b1;
        end
    end

    // Launch FSM state register
    always_ff @(posedge pclk) begin
        if (rst || ship_down) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Launch sequencing: wait for a fire request, give the formation a cycle to answer, then launch
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fire_req) state_d = QUERY;
            QUERY:   state_d = LAUNCH;
            LAUNCH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Round-robin shooter index, advanced after every launch attempt whether or not it fired
    always_ff @(posedge pclk) begin
        if (rst) begin
            shooter_sel_q <= '0;
        end else if (!ship_down && state_q == LAUNCH) begin
            shooter_sel_q <= next_shooter(shooter_sel_q);
        end
    end

    // Lowest-index free slot, judged on registered flags so a slot retiring this cycle is still busy
    always_comb begin
        logic found;
        found      = 1'b0;
        first_free = '0;
        for (int i = 0; i < N_EN_MISSILES; i++) begin
            if (!on_vec[i] && !found) begin
                first_free[i] = 1'b1;
                found         = 1'b1;
            end
        end
        launch_en = (state_q == LAUNCH) && bus.shooter_valid && !ship_down;
        load_vec  = launch_en ? first_free : '0;
        launch_x  = bus.shooter_x + COORD_W'(X_OFFSET);
        launch_y  = bus.shooter_y + COORD_W'(Y_OFFSET);
    end

    for (genvar g = 0; g < N_EN_MISSILES; g++) begin : g_slot
        enemy_missile_slot #(
            .STEP     (STEP),
            .Y_BOTTOM (Y_BOTTOM)
        ) u_slot (
            .pclk      (pclk),
            .rst       (rst),
            .clear     (ship_down),
            .load      (load_vec[g]),
            .load_x    (launch_x),
            .load_y    (launch_y),
            .move_tick (move_tick),
            .x         (slot_x[g]),
            .y         (slot_y[g]),
            .on        (on_vec[g])
        );
    end

    assign bus.shooter_sel   = shooter_sel_q;
    assign bus.missile_on    = on_vec;
    assign bus.en_x_missile1 = slot_x[0];
    assign bus.en_x_missile2 = slot_x[1];
    assign bus.en_x_missile3 = slot_x[2];
    assign bus.en_x_missile4 = slot_x[3];
    assign bus.en_x_missile5 = slot_x[4];
    assign bus.en_y_missile1 = slot_y[0];
    assign bus.en_y_missile2 = slot_y[1];
    assign bus.en_y_missile3 = slot_y[2];
    assign bus.en_y_missile4 = slot_y[3];
    assign bus.en_y_missile5 = slot_y[4];

endmodule

// File: tb/tb_enemy_missile_ctl.sv
// Bench for enemy_missile_ctl: a small enemy formation answers shooter
// lookups, and a time-based reference model predicts every missile slot.
module tb_enemy_missile_ctl;
    import enemy_pkg::*;

    localparam int MD  = 4;
    localparam int FP  = 16;
    localparam int STP = 2;
    localparam int YB  = 767;
    localparam int XO  = 16;
    localparam int YO  = 32;

    logic pclk      = 1'b0;
    logic rst       = 1'b1;
    logic ship_down = 1'b0;

    int total = 0;
    int bad   = 0;

    int ex [5] = '{100, 50, 300, 500, 700};
    int ey [5] = '{200, 730, 100, 150, 250};
    bit ea [5] = '{1, 1, 1, 1, 1};

    int rx [5] = '{0, 0, 0, 0, 0};
    int ry [5] = '{0, 0, 0, 0, 0};
    bit ron [5] = '{0, 0, 0, 0, 0};
    int rsel = 0;
    int t    = 0;
    int lkx  = 0;
    int lky  = 0;
    bit lkv  = 0;

    enemy_missile_ctl_if bus ();

    enemy_missile_ctl #(
        .MOVE_DIV    (MD),
        .STEP        (STP),
        .FIRE_PERIOD (FP),
        .X_OFFSET    (XO),
        .Y_OFFSET    (YO),
        .Y_BOTTOM    (YB)
    ) dut (
        .pclk      (pclk),
        .rst       (rst),
        .ship_down (ship_down),
        .bus       (bus.master)
    );

    // Pixel clock
    always #5 pclk = ~pclk;

    // Enemy formation: answers the selected enemy one cycle after the index is presented
    always @(posedge pclk) begin
        if (bus.shooter_sel < 3'd5) begin
            bus.shooter_x     <= 11'(ex[bus.shooter_sel]);
            bus.shooter_y     <= 11'(ey[bus.shooter_sel]);
            bus.shooter_valid <= ea[bus.shooter_sel];
        end else begin
            bus.shooter_x     <= '0;
            bus.shooter_y     <= '0;
            bus.shooter_valid <= 1'b0;
        end
    end

    // Reference model: launches land two cycles after each fire period ends, moves every MD cycles
    always @(posedge pclk) begin
        int nx [5];
        int ny [5];
        bit non [5];
        int slot;
        int sel_pre;
        bit launch;
        bit tick;
        sel_pre = rsel;
        if (rst || ship_down) begin
            for (int k = 0; k < 5; k++) begin
                rx[k]  = 0;
                ry[k]  = 0;
                ron[k] = 0;
            end
            t = 0;
            if (rst) rsel = 0;
        end else begin
            launch = (t >= FP + 1) && ((t - 2) % FP == FP - 1);
            tick   = (t % MD) == MD - 1;
            slot   = -1;
            for (int k = 0; k < 5; k++) begin
                if (!ron[k] && slot < 0) slot = k;
            end
            for (int k = 0; k < 5; k++) begin
                nx[k]  = rx[k];
                ny[k]  = ry[k];
                non[k] = ron[k];
                if (launch && lkv && k == slot) begin
                    nx[k]  = (lkx + XO) % 2048;
                    ny[k]  = (lky + YO) % 2048;
                    non[k] = 1;
                end else if (tick && ron[k]) begin
                    if (ry[k] + STP > YB) begin
                        nx[k]  = 0;
                        ny[k]  = 0;
                        non[k] = 0;
                    end else begin
                        ny[k] = ry[k] + STP;
                    end
                end
            end
            for (int k = 0; k < 5; k++) begin
                rx[k]  = nx[k];
                ry[k]  = ny[k];
                ron[k] = non[k];
            end
            if (launch) rsel = (rsel + 1) % 5;
            t++;
        end
        lkx = ex[sel_pre];
        lky = ey[sel_pre];
        lkv = ea[sel_pre];
    end

    task automatic checkValue(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        logic [10:0] ox [5];
        logic [10:0] oy [5];
        logic [4:0]  eon;
        ox[0] = bus.en_x_missile1;  oy[0] = bus.en_y_missile1;
        ox[1] = bus.en_x_missile2;  oy[1] = bus.en_y_missile2;
        ox[2] = bus.en_x_missile3;  oy[2] = bus.en_y_missile3;
        ox[3] = bus.en_x_missile4;  oy[3] = bus.en_y_missile4;
        ox[4] = bus.en_x_missile5;  oy[4] = bus.en_y_missile5;
        for (int k = 0; k < 5; k++) begin
            eon[k] = ron[k];
            checkValue($sformatf("x%0d@t%0d", k + 1, t), ox[k], 11'(rx[k]));
            checkValue($sformatf("y%0d@t%0d", k + 1, t), oy[k], 11'(ry[k]));
        end
        checkValue($sformatf("on@t%0d", t), 11'(bus.missile_on), 11'(eon));
        checkValue($sformatf("sel@t%0d", t), 11'(bus.shooter_sel), 11'(rsel));
    endtask

    task automatic applyStimulus(input logic r, input logic sd, input int n);
        rst       = r;
        ship_down = sd;
        for (int i = 0; i < n; i++) begin
            @(posedge pclk);
            @(negedge pclk);
            checkOutput();
        end
    endtask

    initial begin
        $display("[TB] reset");
        applyStimulus(1'b1, 1'b0, 2);
        checkValue("reset_on", 11'(bus.missile_on), 11'd0);
        checkValue("reset_sel", 11'(bus.shooter_sel), 11'd0);
        checkValue("reset_y1", bus.en_y_missile1, 11'd0);

        $display("[TB] first launch");
        applyStimulus(1'b0, 1'b0, 17);
        checkValue("pre_launch_on", 11'(bus.missile_on), 11'd0);
        applyStimulus(1'b0, 1'b0, 1);
        checkValue("launch_x1", bus.en_x_missile1, 11'd116);
        checkValue("launch_y1", bus.en_y_missile1, 11'd232);
        checkValue("launch_on", 11'(bus.missile_on), 11'b00001);
        checkValue("launch_sel", 11'(bus.shooter_sel), 11'd1);
        applyStimulus(1'b0, 1'b0, 2);
        checkValue("move_y1", bus.en_y_missile1, 11'd234);

        $display("[TB] retire at bottom");
        applyStimulus(1'b0, 1'b0, 14);
        checkValue("bottom_x2", bus.en_x_missile2, 11'd66);
        checkValue("bottom_y2a", bus.en_y_missile2, 11'd762);
        applyStimulus(1'b0, 1'b0, 2);
        checkValue("bottom_y2b", bus.en_y_missile2, 11'd764);
        applyStimulus(1'b0, 1'b0, 4);
        checkValue("bottom_y2c", bus.en_y_missile2, 11'd766);
        applyStimulus(1'b0, 1'b0, 4);
        checkValue("retire_y2", bus.en_y_missile2, 11'd0);
        checkValue("retire_x2", bus.en_x_missile2, 11'd0);
        checkValue("retire_on", 11'(bus.missile_on), 11'b00001);

        $display("[TB] saturation");
        applyStimulus(1'b0, 1'b0, 54);
        checkValue("full_on", 11'(bus.missile_on), 11'b11111);
        checkValue("full_sel", 11'(bus.shooter_sel), 11'd1);
        applyStimulus(1'b0, 1'b0, 16);
        checkValue("drop_on", 11'(bus.missile_on), 11'b11111);
        checkValue("drop_sel", 11'(bus.shooter_sel), 11'd2);

        $display("[TB] ship_down");
        applyStimulus(1'b0, 1'b1, 1);
        checkValue("down_on", 11'(bus.missile_on), 11'd0);
        checkValue("down_x5", bus.en_x_missile5, 11'd0);
        applyStimulus(1'b0, 1'b1, 49);
        checkValue("down_sel", 11'(bus.shooter_sel), 11'd2);
        ea[3] = 1'b0;
        applyStimulus(1'b0, 1'b0, 17);
        checkValue("resume_pre_on", 11'(bus.missile_on), 11'd0);
        applyStimulus(1'b0, 1'b0, 1);
        checkValue("resume_x1", bus.en_x_missile1, 11'd316);
        checkValue("resume_y1", bus.en_y_missile1, 11'd132);
        checkValue("resume_sel", 11'(bus.shooter_sel), 11'd3);

        $display("[TB] dead shooter");
        applyStimulus(1'b0, 1'b0, 16);
        checkValue("dead_on", 11'(bus.missile_on), 11'b00001);
        checkValue("dead_sel", 11'(bus.shooter_sel), 11'd4);
        ea[3] = 1'b1;

        $display("[TB] random");
        for (int it = 0; it < 40; it++) begin
            int pick;
            for (int k = 0; k < 5; k++) begin
                ex[k] = $urandom_range(0, 1023);
                ey[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(700, 1023) : $urandom_range(0, 400);
                ea[k] = ($urandom_range(0, 3) != 0);
            end
            pick = $urandom_range(0, 19);
            if (pick == 0) begin
                applyStimulus(1'b1, 1'b0, $urandom_range(1, 3));
            end else if (pick < 3) begin
                applyStimulus(1'b0, 1'b1, $urandom_range(1, 5));
            end
            applyStimulus(1'b0, 1'b0, $urandom_range(10, 40));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
